// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// Module      : rf_pkg
// Description : Shared defaults, address-width helper and word type for the
//               multi-port register file (reg_file_mp).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_NUM_RD   = 2;

  // Address width needed to select one of n registers
  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_AW = rf_aw(DEF_NUM_REGS);

  typedef logic [DEF_DATA_W-1:0] rf_word_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_mp_if.sv
//------------------------------------------------------------------------------
// Module      : reg_file_mp_if
// Description : Bus bundle for reg_file_mp: read ports, write port, issue
//               strobe and sticky error. master = datapath, slave = file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
);

  localparam int AW = rf_aw(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, err
  );

endinterface

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : rf_scoreboard
// Description : Per-register busy tracking and sticky double-issue error.
//               Strobes arrive already qualified (zero-register gating done
//               by the caller).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = rf_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] iss_dec;
  logic [NUM_REGS-1:0] wr_dec;
  logic                dbl_iss;

  assign iss_dec = iss_en ? (ONE_HOT0 << iss_addr) : '0;
  assign wr_dec  = wr_en  ? (ONE_HOT0 << wr_addr)  : '0;

  // A re-issue is only an error if no write retires the old producer this cycle
  assign dbl_iss = iss_en && busy[iss_addr] && !(wr_en && (wr_addr == iss_addr));

  // Busy vector: issue wins over a same-cycle write to the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~wr_dec) | iss_dec;
      err  <= err | dbl_iss;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
//------------------------------------------------------------------------------
// Module      : reg_file_mp
// Description : Parametrised register file, NUM_RD combinational read ports,
//               one synchronous write port, integrated busy scoreboard.
//               Optional macro RF_BYPASS_EN: forward write data (and clear
//               busy) to read ports addressing the register being written.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int AW = rf_aw(NUM_REGS);
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_ok;
  logic                iss_ok;

  // Register 0 swallows writes and issues when it is hardwired to zero
  assign wr_ok  = bus.wr_en  && !(HAS_ZERO && (bus.wr_addr  == '0));
  assign iss_ok = bus.iss_en && !(HAS_ZERO && (bus.iss_addr == '0));

  // Data array: asynchronous clear so reads drop to zero at reset assertion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_ok),
    .iss_addr (bus.iss_addr),
    .wr_en    (wr_ok),
    .wr_addr  (bus.wr_addr),
    .busy     (busy),
    .err      (bus.err)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero_hit;

    assign ra       = bus.rd_addr[p*AW +: AW];
    assign zero_hit = HAS_ZERO && (ra == '0);

`ifdef RF_BYPASS_EN
    logic fwd;
    logic iss_same;

    // Forwarding is suppressed during reset so the array clear is visible at once
    assign fwd      = rst && wr_ok && (ra == bus.wr_addr);
    assign iss_same = iss_ok && (ra == bus.iss_addr);

    assign bus.rd_data[p*DATA_W +: DATA_W] = zero_hit ? '0 :
                                             fwd      ? bus.wr_data : regs[ra];
    assign bus.rd_busy[p]                  = zero_hit ? 1'b0 :
                                             fwd      ? iss_same : busy[ra];
`else
    assign bus.rd_data[p*DATA_W +: DATA_W] = zero_hit ? '0   : regs[ra];
    assign bus.rd_busy[p]                  = zero_hit ? 1'b0 : busy[ra];
`endif
  end

endmodule

`default_nettype wire
